// File: rtl/riscv_mem_responder_pkg.sv
// Shared widths, FSM encoding and response-beat layout for the memory responder.
// Memory-port widths live here so requester and responder agree on them.
package riscv_mem_responder_pkg;

    localparam int MEM_ADDR_BITS = 32;
    localparam int MEM_DATA_BITS = 32;
    localparam int MEM_TAG_BITS  = 5;

    typedef enum logic [0:0] {
        RSP_RUN     = 1'b0,
        RSP_REFRESH = 1'b1
    } rsp_state_t;

    typedef struct packed {
        logic                     val;
        logic                     nack;
        logic [MEM_TAG_BITS-1:0]  tag;
        logic [MEM_DATA_BITS-1:0] data;
    } resp_beat_t;

    // Bits needed to count 0..max_val inclusive; never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/riscv_mem_responder_if.sv
// Core memory port: request channel with val/rdy, response channel without backpressure.
// master = core/arbiter side, slave = responder side.
interface riscv_mem_responder_if import riscv_mem_responder_pkg::*; ();

    logic                     mem_req_val;
    logic                     mem_req_rdy;
    logic                     mem_req_rw;
    logic [MEM_ADDR_BITS-1:0] mem_req_addr;
    logic [MEM_DATA_BITS-1:0] mem_req_data;
    logic [MEM_TAG_BITS-1:0]  mem_req_tag;

    logic                     mem_resp_val;
    logic                     mem_resp_nack;
    logic [MEM_DATA_BITS-1:0] mem_resp_data;
    logic [MEM_TAG_BITS-1:0]  mem_resp_tag;

    modport master (
        output mem_req_val, mem_req_rw, mem_req_addr, mem_req_data, mem_req_tag,
        input  mem_req_rdy,
        input  mem_resp_val, mem_resp_nack, mem_resp_data, mem_resp_tag
    );

    modport slave (
        input  mem_req_val, mem_req_rw, mem_req_addr, mem_req_data, mem_req_tag,
        output mem_req_rdy,
        output mem_resp_val, mem_resp_nack, mem_resp_data, mem_resp_tag
    );

endinterface

// File: rtl/riscv_mem_resp_pipe.sv
// Delays a response beat by DEPTH registered stages (DEPTH = 0 is a straight wire).
// Never stalls; reset empties every stage so in-flight responses are dropped.
module riscv_mem_resp_pipe import riscv_mem_responder_pkg::*; #(
    parameter int DEPTH = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  resp_beat_t i_beat,
    output resp_beat_t o_beat
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_beat = i_beat;
        end else begin : g_stages
            resp_beat_t r_stage [DEPTH];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= i_beat;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_beat = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/riscv_mem_responder.sv
// Word-array memory target: reads answer LATENCY cycles after accept with the echoed tag, writes are silent.
// rdy drops for REFRESH_CYCLES every REFRESH_PERIOD run cycles; every NACK_EVERY-th read is nacked.
module riscv_mem_responder import riscv_mem_responder_pkg::*; #(
    parameter int WORDS          = 4096,
    parameter int LATENCY        = 4,
    parameter int NACK_EVERY     = 0,
    parameter int REFRESH_PERIOD = 0,
    parameter int REFRESH_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    riscv_mem_responder_if.slave mem
);

    localparam int IDX_W  = $clog2(WORDS);
    localparam int REF_W  = cnt_width((REFRESH_PERIOD > REFRESH_CYCLES) ? REFRESH_PERIOD : REFRESH_CYCLES);
    localparam int NACK_W = cnt_width(NACK_EVERY);

    localparam logic [REF_W-1:0]  REF_RUN_LAST  = REF_W'((REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0);
    localparam logic [REF_W-1:0]  REF_HOLD_LAST = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [NACK_W-1:0] NACK_LAST     = NACK_W'((NACK_EVERY > 0) ? NACK_EVERY - 1 : 0);

    logic [MEM_DATA_BITS-1:0] r_mem [WORDS];
    rsp_state_t               r_state;
    logic [REF_W-1:0]         r_ref_cnt;
    logic [NACK_W-1:0]        r_nack_cnt;
    resp_beat_t               r_beat0;

    resp_beat_t               w_beat_out;
    logic                     w_rdy;
    logic                     w_fire;
    logic                     w_wr_fire;
    logic                     w_rd_fire;
    logic                     w_nack_hit;
    logic [IDX_W-1:0]         w_idx;
    logic                     w_unused_addr;

    assign w_rdy      = ~reset & (r_state == RSP_RUN);
    assign w_fire     = mem.mem_req_val & w_rdy;
    assign w_wr_fire  = w_fire & mem.mem_req_rw;
    assign w_rd_fire  = w_fire & ~mem.mem_req_rw;
    assign w_nack_hit = (NACK_EVERY != 0) && (r_nack_cnt == NACK_LAST);

    // Upper address bits alias onto the array, so addresses wrap modulo WORDS.
    assign w_idx         = mem.mem_req_addr[IDX_W-1:0];
    assign w_unused_addr = ^mem.mem_req_addr[MEM_ADDR_BITS-1:IDX_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RSP_RUN;
            r_ref_cnt <= '0;
        end else begin
            case (r_state)
                RSP_RUN: begin
                    if (REFRESH_PERIOD != 0 && r_ref_cnt == REF_RUN_LAST) begin
                        r_state   <= RSP_REFRESH;
                        r_ref_cnt <= '0;
                    end else if (REFRESH_PERIOD != 0) begin
                        r_ref_cnt <= r_ref_cnt + 1'b1;
                    end
                end
                RSP_REFRESH: begin
                    if (r_ref_cnt == REF_HOLD_LAST) begin
                        r_state   <= RSP_RUN;
                        r_ref_cnt <= '0;
                    end else begin
                        r_ref_cnt <= r_ref_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= RSP_RUN;
                    r_ref_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_nack_cnt <= '0;
        end else if (w_rd_fire && NACK_EVERY != 0) begin
            r_nack_cnt <= w_nack_hit ? '0 : r_nack_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[w_idx] <= mem.mem_req_data;
        end
    end

    // Stage 0 samples the array before this edge's write lands, giving read-before-write order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat0 <= '0;
        end else begin
            r_beat0.val  <= w_rd_fire;
            r_beat0.nack <= w_rd_fire & w_nack_hit;
            r_beat0.tag  <= w_rd_fire ? mem.mem_req_tag : '0;
            r_beat0.data <= (w_rd_fire & ~w_nack_hit) ? r_mem[w_idx] : '0;
        end
    end

    riscv_mem_resp_pipe #(
        .DEPTH (LATENCY - 1)
    ) u_resp_pipe (
        .clk    (clk),
        .reset  (reset),
        .i_beat (r_beat0),
        .o_beat (w_beat_out)
    );

    assign mem.mem_req_rdy   = w_rdy;
    assign mem.mem_resp_val  = w_beat_out.val;
    assign mem.mem_resp_nack = w_beat_out.nack;
    assign mem.mem_resp_tag  = w_beat_out.tag;
    assign mem.mem_resp_data = w_beat_out.data;

endmodule
